regfile_mp: RTL

Parametrised multi-port general-purpose register file for the RISC-V core. It replaces the fixed 2-read/1-write `regfile` between decode (`id`) and write-back (`wb`). It adds configurable read and write port counts, same-cycle write-to-read bypass, and write-port conflict detection. A hardware clear sweep after reset zeroes every register, so simulation no longer depends on a `$readmemh` preload.

---
 rtl/regfile_mp_pkg.sv | 6 +
 rtl/regfile_rd_port.sv | 27 ++
 rtl/regfile_mp.sv | 83 ++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and sweep-FSM state encoding for the multi-port register file
package regfile_mp_pkg;
   localparam int ZERO_REG = 0;
   localparam logic [31:0] ZERO_WORD = '0;
   typedef enum logic {RF_ST_CLEAR = 1'b0, RF_ST_RUN = 1'b1} rf_state_e;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port with same-cycle write bypass and zero gating
module regfile_rd_port
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_WR = 2,
   parameter int BYPASS = 1
) (
   input  logic [ADDR_W-1:0]        raddr,
   input  logic                     re,
   input  logic                     busy,
   input  logic [DATA_W-1:0]        mem_data,
   input  logic [NUM_WR*ADDR_W-1:0] waddr,
   input  logic [NUM_WR-1:0]        wv,
   input  logic [NUM_WR*DATA_W-1:0] wdata,
   output logic [DATA_W-1:0]        rdata
);
   // later ports overwrite earlier matches, so the highest-index writer wins
   always_comb begin
      rdata = mem_data;
      if (BYPASS != 0)
         for (int i = 0; i < NUM_WR; i++)
            if (wv[i] && waddr[i*ADDR_W +: ADDR_W] == raddr) rdata = wdata[i*DATA_W +: DATA_W];
      if (!re || busy || raddr == ADDR_W'(ZERO_REG)) rdata = DATA_W'(ZERO_WORD);
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port GPR file with post-reset clear sweep and write-conflict flag
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
   input  logic [NUM_RD-1:0]        re_i,
   output logic [NUM_RD*DATA_W-1:0] rdata_o,
   input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
   input  logic [NUM_WR-1:0]        we_i,
   input  logic [NUM_WR*DATA_W-1:0] wdata_i,
   output logic                     init_busy_o,
   output logic                     wr_conflict_o
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] gpr [DEPTH];
   rf_state_e state, state_nx;
   logic [ADDR_W-1:0] clr_cnt, clr_nx;
   logic [NUM_WR-1:0] wv;
   logic conflict;
   assign init_busy_o = rst || state == RF_ST_CLEAR;
   always_comb begin
      wv = '0;
      for (int i = 0; i < NUM_WR; i++)
         wv[i] = we_i[i] && waddr_i[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG) && !init_busy_o;
   end
   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < NUM_WR; i++)
         for (int j = i + 1; j < NUM_WR; j++)
            if (wv[i] && wv[j] && waddr_i[i*ADDR_W +: ADDR_W] == waddr_i[j*ADDR_W +: ADDR_W]) conflict = 1'b1;
   end
   always_comb begin
      state_nx = state;
      clr_nx = clr_cnt;
      if (state == RF_ST_CLEAR) begin
         clr_nx = clr_cnt + 1'b1;
         state_nx = clr_cnt == '1 ? RF_ST_RUN : RF_ST_CLEAR;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= RF_ST_CLEAR;
         clr_cnt <= ADDR_W'(1);
         wr_conflict_o <= 1'b0;
      end else begin
         state <= state_nx;
         clr_cnt <= clr_nx;
         wr_conflict_o <= conflict;
      end
   // x0 is never written; every read of address 0 is gated to zero instead
   always_ff @(posedge clk)
      if (!rst) begin
         if (state == RF_ST_CLEAR) gpr[clr_cnt] <= DATA_W'(ZERO_WORD);
         else
            for (int i = 0; i < NUM_WR; i++)
               if (wv[i]) gpr[waddr_i[i*ADDR_W +: ADDR_W]] <= wdata_i[i*DATA_W +: DATA_W];
      end
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_rd_port #(
         .DATA_W(DATA_W),
         .ADDR_W(ADDR_W),
         .NUM_WR(NUM_WR),
         .BYPASS(BYPASS)
      ) u_rd (
         .raddr(raddr_i[k*ADDR_W +: ADDR_W]),
         .re(re_i[k]),
         .busy(init_busy_o),
         .mem_data(gpr[raddr_i[k*ADDR_W +: ADDR_W]]),
         .waddr(waddr_i),
         .wv(wv),
         .wdata(wdata_i),
         .rdata(rdata_o[k*DATA_W +: DATA_W])
      );
   end
endmodule
